// File: rtl/axi_st_d256_gen1_gen2_slave_rx.sv
// Receive-side FIFO that turns 289-bit link words into an AXI-Stream master.
// It returns one credit pulse per word handed to the user.
module axi_st_d256_gen1_gen2_slave_rx #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 289
) (
    input  logic             clk_wr,
    input  logic             rst_wr,
    input  logic             rx_online,
    input  logic             rx_st_pushbit,
    input  logic [WIDTH-1:0] rx_st_data,
    output logic             user_tvalid,
    output logic [255:0]     user_tdata,
    output logic [31:0]      user_tkeep,
    output logic             user_tlast,
    input  logic             user_tready,
    output logic             tx_st_credit,
    output logic [31:0]      rx_st_debug_status
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [7:0]       count_reg, count_next;
    logic             ovf_reg, ovf_next;
    logic             credit_reg, credit_next;
    logic [15:0]      credit_cnt_reg, credit_cnt_next;

    logic empty, full, push, pop;

    assign empty       = (count_reg == 8'd0);
    assign full        = (count_reg == 8'(DEPTH));
    assign user_tvalid = !empty;
    // Offline cycles flush the FIFO, so a pop there must not earn a credit.
    assign pop         = user_tvalid & user_tready & rx_online;
    assign push        = rx_online & rx_st_pushbit & (!full | pop);

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        ovf_next        = ovf_reg;
        credit_next     = 1'b0;
        credit_cnt_next = credit_cnt_reg;
        if (!rx_online) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = 8'd0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next     = rd_ptr_reg + PTR_W'(1);
                credit_next     = 1'b1;
                credit_cnt_next = credit_cnt_reg + 16'd1;
            end
            count_next = count_reg + 8'(push) - 8'(pop);
            if (rx_st_pushbit && full && !pop) begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= 8'd0;
            ovf_reg        <= 1'b0;
            credit_reg     <= 1'b0;
            credit_cnt_reg <= 16'd0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            ovf_reg        <= ovf_next;
            credit_reg     <= credit_next;
            credit_cnt_reg <= credit_cnt_next;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (push && !rst_wr) begin
            mem[wr_ptr_reg] <= rx_st_data;
        end
    end

    // Registered read of the next head; a word written into that slot this
    // cycle is forwarded so an empty FIFO still shows data one cycle later.
    always_ff @(posedge clk_wr) begin
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= rx_st_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    assign user_tkeep   = head_reg[31:0];
    assign user_tdata   = head_reg[287:32];
    assign user_tlast   = head_reg[288];
    assign tx_st_credit = credit_reg;

    assign rx_st_debug_status = {credit_cnt_reg, 5'b0, empty, full, ovf_reg, count_reg};

endmodule

// File: tb/tb_axi_st_d256_gen1_gen2_slave_rx.sv
// Bench for the receive FIFO: table vectors, directed corner sequences and a
// randomized soak, all compared against a queue-based reference model.
module tb_axi_st_d256_gen1_gen2_slave_rx;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_wr = 1'b1;
    logic         rx_online = 1'b0;
    logic         rx_st_pushbit = 1'b0;
    logic [288:0] rx_st_data = '0;
    logic         user_tready = 1'b0;
    logic         user_tvalid;
    logic [255:0] user_tdata;
    logic [31:0]  user_tkeep;
    logic         user_tlast;
    logic         tx_st_credit;
    logic [31:0]  rx_st_debug_status;

    axi_st_d256_gen1_gen2_slave_rx #(.DEPTH(DEPTH), .WIDTH(289)) dut (
        .clk_wr             (clk),
        .rst_wr             (rst_wr),
        .rx_online          (rx_online),
        .rx_st_pushbit      (rx_st_pushbit),
        .rx_st_data         (rx_st_data),
        .user_tvalid        (user_tvalid),
        .user_tdata         (user_tdata),
        .user_tkeep         (user_tkeep),
        .user_tlast         (user_tlast),
        .user_tready        (user_tready),
        .tx_st_credit       (tx_st_credit),
        .rx_st_debug_status (rx_st_debug_status)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO is a plain queue of whole words.
    logic [288:0] q [$];
    bit           m_ovf;
    logic [15:0]  m_credits;
    bit           m_credit;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        bit online;
        bit push;
        bit rdy;
        int id;
        bit e_valid;
        bit e_credit;
        int e_count;
        int e_head;
    } vec_t;

    vec_t tbl [10];

    task automatic check(string name, logic [288:0] act, logic [288:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [288:0] make_word(int id);
        logic [288:0] w;
        w[31:0]   = 32'hF0F0_0000 | 32'(id);
        w[287:32] = {8{32'hA5A5_0000 + 32'(id)}};
        w[288]    = id[0];
        return w;
    endfunction

    function automatic logic [288:0] rand_word();
        logic [288:0] w;
        for (int k = 0; k < 9; k++) w[k*32 +: 32] = $urandom;
        w[288] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    function automatic logic [31:0] model_status();
        logic [7:0] cnt;
        cnt = 8'(q.size());
        return {m_credits, 5'b0, (q.size() == 0), (q.size() == DEPTH), m_ovf, cnt};
    endfunction

    task automatic model_update(bit rst, bit online, bit push, logic [288:0] d, bit rdy);
        bit do_pop;
        bit was_full;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_credits = 16'd0;
            m_credit = 0;
        end else if (!online) begin
            q.delete();
            m_credit = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            do_pop   = (q.size() != 0) && rdy;
            m_credit = do_pop;
            if (do_pop) begin
                void'(q.pop_front());
                m_credits = m_credits + 16'd1;
            end
            if (push) begin
                if (!was_full || do_pop) q.push_back(d);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic compare_model();
        check("tvalid", 289'(user_tvalid), 289'(q.size() != 0));
        check("credit", 289'(tx_st_credit), 289'(m_credit));
        check("status", 289'(rx_st_debug_status), 289'(model_status()));
        if (q.size() != 0)
            check("head", {user_tlast, user_tdata, user_tkeep}, q[0]);
    endtask

    task automatic step(bit rst, bit online, bit push, logic [288:0] d, bit rdy);
        rst_wr        = rst;
        rx_online     = online;
        rx_st_pushbit = push;
        rx_st_data    = d;
        user_tready   = rdy;
        @(posedge clk);
        model_update(rst, online, push, d, rdy);
        @(negedge clk);
        cyc++;
        $display("cyc %0d rst=%0b on=%0b push=%0b rdy=%0b -> tvalid=%0b credit=%0b status=%h",
                 cyc, rst, online, push, rdy, user_tvalid, tx_st_credit, rx_st_debug_status);
        compare_model();
    endtask

    task automatic do_reset();
        step(1, 1, 0, '0, 0);
        step(1, 1, 0, '0, 0);
    endtask

    initial begin
        int pulses;
        logic [288:0] w;

        @(negedge clk);

        // Reset state
        do_reset();
        check("reset_status", 289'(rx_st_debug_status), 289'(32'h0000_0400));
        check("reset_tvalid", 289'(user_tvalid), 289'(0));

        // Table vectors from an empty FIFO
        tbl[0] = '{1, 1, 0, 1, 1, 0, 1, 1};
        tbl[1] = '{1, 1, 0, 2, 1, 0, 2, 1};
        tbl[2] = '{1, 0, 1, 0, 1, 1, 1, 2};
        tbl[3] = '{1, 1, 1, 3, 1, 1, 1, 3};
        tbl[4] = '{1, 0, 1, 0, 0, 1, 0, 0};
        tbl[5] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 1, 0, 4, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 1, 5, 1, 0, 1, 5};
        tbl[8] = '{1, 0, 0, 0, 1, 0, 1, 5};
        tbl[9] = '{0, 0, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].online, tbl[i].push, make_word(tbl[i].id), tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), 289'(user_tvalid), 289'(tbl[i].e_valid));
            check($sformatf("tbl%0d_credit", i), 289'(tx_st_credit), 289'(tbl[i].e_credit));
            check($sformatf("tbl%0d_count", i), 289'(rx_st_debug_status[7:0]), 289'(tbl[i].e_count));
            if (tbl[i].e_valid)
                check($sformatf("tbl%0d_head", i), {user_tlast, user_tdata, user_tkeep},
                      make_word(tbl[i].e_head));
        end

        // Single word with credit return
        do_reset();
        w = {1'b1, {32{8'hA5}}, 32'hFFFF_FFFF};
        step(0, 1, 1, w, 1);
        check("single_head", {user_tlast, user_tdata, user_tkeep}, w);
        step(0, 1, 0, '0, 1);
        check("single_credit", 289'(tx_st_credit), 289'(1));
        check("single_ccnt", 289'(rx_st_debug_status[31:16]), 289'(1));
        step(0, 1, 0, '0, 1);
        check("single_credit_end", 289'(tx_st_credit), 289'(0));

        // Fill, overflow, drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, make_word(16 + i), 0);
        check("fill_full", 289'(rx_st_debug_status[9:0]), 289'(10'h208));
        step(0, 1, 1, make_word(99), 0);
        check("fill_ovf", 289'(rx_st_debug_status[9:0]), 289'(10'h308));
        pulses = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(0, 1, 0, '0, 1);
            if (tx_st_credit) pulses++;
        end
        check("drain_pulses", 289'(pulses), 289'(DEPTH));

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, make_word(32 + i), 0);
        step(0, 1, 1, make_word(40), 1);
        check("full_pushpop", 289'(rx_st_debug_status[9:0]), 289'(10'h208));
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, '0, 1);

        // Backpressure with alternating ready
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 1, 1, rand_word(), bit'(i % 2 == 0));
        for (int i = 0; i < 30; i++) step(0, 1, 0, '0, bit'(i % 2 == 0));
        check("bp_empty", 289'(rx_st_debug_status[7:0]), 289'(0));

        // Link drop with words queued
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 1, make_word(48 + i), 0);
        step(0, 0, 1, make_word(60), 1);
        check("offline_tvalid", 289'(user_tvalid), 289'(0));
        check("offline_count", 289'(rx_st_debug_status[7:0]), 289'(0));
        check("offline_credit", 289'(tx_st_credit), 289'(0));
        step(0, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, make_word(64 + i), bit'(i % 2));
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0, 1);

        // Reset with words queued and ready high
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 1, make_word(80 + i), 0);
        step(1, 1, 1, make_word(90), 1);
        check("rst_credit", 289'(tx_st_credit), 289'(0));
        check("rst_status", 289'(rx_st_debug_status), 289'(32'h0000_0400));
        step(0, 1, 0, '0, 1);
        check("rst_credit_after", 289'(tx_st_credit), 289'(0));

        // Randomized soak
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 99) == 0), bit'($urandom_range(0, 19) != 0),
                 bit'($urandom_range(0, 2) != 0), rand_word(), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
